mux_arb_pipe: RTL and testbench

MUX_ARB_PIPE -- requirements
Module: mux_arb_pipe

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_arb_pipe_rr_pick.sv | 37 +++
 rtl/mux_arb_pipe.sv | 114 +++++++++++
 tb/tb_mux_arb_pipe.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the channel-select / arbitration pipeline.
package mux_pkg;

   // How the output stage chooses which input channel to take a word from.
   typedef enum logic [0:0] {
      MODE_SEL = 1'b0,   // channel index comes from the sel port
      MODE_RR  = 1'b1    // rotating-priority arbitration over valid channels
   } mode_e;

   // Width of a channel index; never less than one bit.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mux_arb_pipe_rr_pick.sv
// Rotating-priority picker: first requester at or above ptr, wrapping to 0.
module rr_pick
   import mux_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx,
   output logic                 any
);

   localparam int CW = chan_w(N);

   // Scan from the farthest candidate back toward ptr so the nearest request wins;
   // index arithmetic wraps naturally because N is a power of two.
   always_comb begin
      idx = ptr;
      any = 1'b0;
      for (int k = N-1; k >= 0; k--) begin
         if (req[ptr + CW'(k)]) begin
            idx = ptr + CW'(k);
            any = 1'b1;
         end
      end
   end

   // One-hot form of the winning index.
   always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++) begin
         gnt[i] = any && (idx == CW'(i));
      end
   end

endmodule

// File: rtl/mux_arb_pipe.sv
// N:1 channel select / round-robin arbiter feeding a single output register
// with full-throughput valid/ready handshaking.
module mux_arb_pipe
   import mux_pkg::*;
#(
   parameter int    N    = 8,
   parameter int    W    = 32,
   parameter mode_e MODE = MODE_SEL
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [N*W-1:0]       in_data,
   input  logic [$clog2(N)-1:0] sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_chan
);

   localparam int CW = chan_w(N);

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q,  out_data_d;
   logic [CW-1:0] out_chan_q,  out_chan_d;

   logic          load;      // output register may take a new word this cycle
   logic [CW-1:0] g;         // candidate channel
   logic [N-1:0]  ready;
   logic          xfer;      // an input transfer happens at the next edge
   logic [W-1:0]  word;

   assign load = !out_valid_q || out_ready;

   if (MODE == MODE_RR) begin : g_rr
      logic [CW-1:0] ptr_q, ptr_d;
      logic [N-1:0]  gnt;
      logic [CW-1:0] idx;
      logic          any;
      logic          unused_sel;

      assign unused_sel = ^sel;

      rr_pick #(.N(N)) u_pick (
         .req (in_valid),
         .ptr (ptr_q),
         .gnt (gnt),
         .idx (idx),
         .any (any)
      );

      assign g     = idx;
      assign ready = load ? gnt : '0;

      // Pointer moves just past the channel that was served; otherwise holds.
      always_comb begin
         ptr_d = ptr_q;
         if (xfer) ptr_d = g + CW'(1);
      end

      // Pointer register.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) ptr_q <= '0;
         else          ptr_q <= ptr_d;
      end
   end else begin : g_sel
      assign g = sel;

      // Only the selected channel may see ready, and only if it is offering a word.
      always_comb begin
         ready    = '0;
         ready[g] = load && in_valid[g];
      end
   end

   assign xfer     = |ready;
   assign in_ready = ready;

   // Parametrised N:1 word select driven by the chosen channel.
   assign word = in_data[g*W +: W];

   // Output register next state: load on input transfer, drain on output transfer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = word;
         out_chan_d  = g;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // Output register; reset discards any held word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_arb_pipe.sv
// Bench for mux_arb_pipe: one MODE_SEL (N=8) and one MODE_RR (N=4) instance
// checked every cycle against a transaction-level model.
module tb_mux_arb_pipe;
   import mux_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // MODE_SEL instance signals
   logic [7:0]  s_vld, s_rdy;
   logic [63:0] s_data;
   logic [2:0]  s_sel;
   logic        s_ordy, s_ov;
   logic [7:0]  s_od;
   logic [2:0]  s_oc;

   // MODE_RR instance signals
   logic [3:0]  r_vld, r_rdy;
   logic [31:0] r_data;
   logic [1:0]  r_sel;
   logic        r_ordy, r_ov;
   logic [7:0]  r_od;
   logic [1:0]  r_oc;

   mux_arb_pipe #(.N(8), .W(8), .MODE(MODE_SEL)) u_sel (
      .clk(clk), .reset_n(rst_n), .in_valid(s_vld), .in_ready(s_rdy),
      .in_data(s_data), .sel(s_sel), .out_valid(s_ov), .out_ready(s_ordy),
      .out_data(s_od), .out_chan(s_oc));

   mux_arb_pipe #(.N(4), .W(8), .MODE(MODE_RR)) u_rr (
      .clk(clk), .reset_n(rst_n), .in_valid(r_vld), .in_ready(r_rdy),
      .in_data(r_data), .sel(r_sel), .out_valid(r_ov), .out_ready(r_ordy),
      .out_data(r_od), .out_chan(r_oc));

   int n_chk  = 0;
   int n_fail = 0;

   // model state: output register contents and arbitration pointer
   int m_sv, m_sd, m_sc;
   int m_rv, m_rd, m_rc, m_ptr;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Channel the SEL instance should take from now, or -1.
   function automatic int s_pick();
      if ((m_sv == 0 || s_ordy) && s_vld[s_sel]) return int'(s_sel);
      return -1;
   endfunction

   // Channel the RR instance should take from now, or -1.
   function automatic int r_pick();
      if (m_rv != 0 && !r_ordy) return -1;
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (m_ptr + k) % 4;
         if (r_vld[c]) return c;
      end
      return -1;
   endfunction

   task automatic chk_outs(input string tag);
      chk({tag, "_s_valid"}, s_ov, m_sv);
      chk({tag, "_s_data"},  s_od, m_sd);
      chk({tag, "_s_chan"},  s_oc, m_sc);
      chk({tag, "_r_valid"}, r_ov, m_rv);
      chk({tag, "_r_data"},  r_od, m_rd);
      chk({tag, "_r_chan"},  r_oc, m_rc);
   endtask

   // One clock: entered just after a falling edge with inputs already set.
   task automatic cyc();
      int sg, rg;
      #1;
      sg = s_pick();
      rg = r_pick();
      chk("s_in_ready", s_rdy, (sg >= 0) ? (32'd1 << sg) : 32'd0);
      chk("r_in_ready", r_rdy, (rg >= 0) ? (32'd1 << rg) : 32'd0);
      @(posedge clk);
      if (sg >= 0) begin
         m_sv = 1; m_sd = int'(s_data[sg*8 +: 8]); m_sc = sg;
      end else if (s_ordy) m_sv = 0;
      if (rg >= 0) begin
         m_rv = 1; m_rd = int'(r_data[rg*8 +: 8]); m_rc = rg; m_ptr = (rg + 1) % 4;
      end else if (r_ordy) m_rv = 0;
      @(negedge clk);
      chk_outs("cyc");
   endtask

   task automatic model_reset();
      m_sv = 0; m_sd = 0; m_sc = 0;
      m_rv = 0; m_rd = 0; m_rc = 0; m_ptr = 0;
   endtask

   // Assert reset between edges, check the clear is immediate, hold, release on a falling edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_outs("rst_async");
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_outs("rst_hold");
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp35 [3] = '{3, 1, 3};
      int low;

      s_vld = '0; s_data = '0; s_sel = '0; s_ordy = 1'b0;
      r_vld = '0; r_data = '0; r_sel = '0; r_ordy = 1'b0;
      model_reset();
      #1;
      chk_outs("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // SEL picks channel 5; RR cycles through all four channels in order.
      for (int i = 0; i < 8; i++) s_data[i*8 +: 8] = 8'(8'h10 + i);
      s_vld = '1; s_sel = 3'd5; s_ordy = 1'b1;
      r_vld = '1; r_ordy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         r_data = $urandom;
         cyc();
         if (k == 0) begin
            chk("p32_rdy",  s_rdy, 8'h20);
            chk("p32_data", s_od,  8'h15);
            chk("p32_chan", s_oc,  3'd5);
            chk("p32_vld",  s_ov,  1'b1);
         end
         chk("p34_chan", r_oc, 32'(k % 4));
      end

      // Stall holds 8'hA3 while sel wanders, then the next word loads with no bubble.
      s_data[2*8 +: 8] = 8'hA3; s_sel = 3'd2;
      cyc();
      chk("p33_load", s_od, 8'hA3);
      s_ordy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         s_sel  = 3'(k + 4);
         s_data = {$urandom, $urandom};
         r_data = $urandom;
         cyc();
         chk("p33_hold", s_od, 8'hA3);
         chk("p33_rdy",  s_rdy, 8'h00);
      end
      s_ordy = 1'b1; s_sel = 3'd6; s_data[6*8 +: 8] = 8'h5C;
      cyc();
      chk("p33_next", s_od, 8'h5C);
      chk("p33_nobubble", s_ov, 1'b1);

      // RR wrap: land ptr on 3, then only channels 1 and 3, then only 1.
      r_vld = 4'b0100;
      cyc();
      chk("p35_pre", r_oc, 2'd2);
      r_vld = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         r_data = $urandom;
         cyc();
         chk("p35_wrap", r_oc, 32'(exp35[k]));
      end
      r_vld = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("p35_single", r_oc, 2'd1);
      end

      // Idle: out_valid drains after one cycle and stays low.
      s_vld = '0; r_vld = '0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("p37_s_vld", s_ov, 1'b0);
         chk("p37_r_vld", r_ov, 1'b0);
         chk("p37_r_rdy", r_rdy, 4'h0);
      end

      // Random traffic with occasional mid-stream resets.
      for (int n = 0; n < 400; n++) begin
         s_vld  = 8'($urandom);
         s_sel  = 3'($urandom);
         s_ordy = ($urandom_range(0, 3) != 0);
         s_data = {$urandom, $urandom};
         r_vld  = 4'($urandom);
         r_sel  = 2'($urandom);
         r_ordy = ($urandom_range(0, 3) != 0);
         r_data = $urandom;
         if (n % 97 == 50) begin
            do_reset();
            r_vld  = 4'($urandom_range(1, 15));
            r_ordy = 1'b1;
            low = 0;
            for (int c = 3; c >= 0; c--) if (r_vld[c]) low = c;
            cyc();
            chk("p36_first", r_oc, 32'(low));
         end else begin
            cyc();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
